frame_column_loader: RTL and testbench



---
 rtl/frame_cfg_pkg.sv | 20 ++
 rtl/frame_strobe_decode.sv | 20 ++
 rtl/frame_column_loader.sv | 114 +++++++++++
 tb/tb_frame_column_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// rtl/frame_cfg_pkg.sv - shared FSM states, sync word and header field positions for the frame column loader
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        SKIP,
        DATA,
        STROBE
    } state_t;

    localparam logic [31:0] SYNC_WORD    = 32'hFAB0_FAB1;

    localparam int          HDR_DESYNC   = 31;
    localparam int          HDR_COL_HI   = 12;
    localparam int          HDR_COL_LO   = 8;
    localparam int          HDR_FRAME_HI = 4;
    localparam int          HDR_FRAME_LO = 0;

endpackage

// File: rtl/frame_strobe_decode.sv
// rtl/frame_strobe_decode.sv - 5-bit frame index to one-hot strobe decoder with out-of-range flag
// Ports: index (frame index in), onehot (one-hot strobe out, all zero when out of range),
//        out_of_range (index >= MaxFramesPerCol).
module frame_strobe_decode #(
    parameter int MaxFramesPerCol = 20
) (
    input  logic [4:0]                 index,
    output logic [MaxFramesPerCol-1:0] onehot,
    output logic                       out_of_range
);

    always_comb begin
        onehot       = '0;
        out_of_range = (int'(index) >= MaxFramesPerCol);
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            onehot[i] = (int'(index) == i);
        end
    end

endmodule

// File: rtl/frame_column_loader.sv
// rtl/frame_column_loader.sv - sync-locked configuration word loader driving FrameData/FrameStrobe of one fabric column
// Ports: CLK, resetn (async active-low); WriteData/WriteValid/WriteReady word stream in;
//        FrameData/FrameStrobe to the column tiles; ConfigActive (synced); FrameError (sticky).
module frame_column_loader
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int ColumnIndex     = 0
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [31:0]                WriteData,
    input  logic                       WriteValid,
    output logic                       WriteReady,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       ConfigActive,
    output logic                       FrameError
);

    state_t                     state, state_next;
    logic   [4:0]               frame_idx;
    logic   [4:0]               dec_index;
    logic   [MaxFramesPerCol-1:0] dec_onehot;
    logic                       dec_oor;
    logic                       accept;
    logic                       latch_idx;
    logic                       load_data;
    logic                       set_error;
    logic   [4:0]               hdr_col;

    // Ready depends on state only so the upstream valid never loops back into ready.
    assign WriteReady = (state != STROBE);
    assign accept     = WriteValid && WriteReady;
    assign hdr_col    = WriteData[HDR_COL_HI:HDR_COL_LO];

    // One decoder serves both the header range check and the data-phase strobe.
    assign dec_index  = (state == DATA) ? frame_idx : WriteData[HDR_FRAME_HI:HDR_FRAME_LO];

    frame_strobe_decode #(
        .MaxFramesPerCol(MaxFramesPerCol)
    ) u_decode (
        .index       (dec_index),
        .onehot      (dec_onehot),
        .out_of_range(dec_oor)
    );

    always_comb begin
        state_next = state;
        latch_idx  = 1'b0;
        load_data  = 1'b0;
        set_error  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && WriteData == SYNC_WORD) state_next = HEADER;
            end
            HEADER: begin
                if (accept) begin
                    // The sync word has the desync bit set, so it must be matched first
                    // to stay a harmless re-sync while already locked.
                    if (WriteData == SYNC_WORD) begin
                        state_next = HEADER;
                    end else if (WriteData[HDR_DESYNC]) begin
                        state_next = IDLE;
                    end else if (hdr_col != 5'(ColumnIndex)) begin
                        state_next = SKIP;
                    end else if (dec_oor) begin
                        set_error  = 1'b1;
                        state_next = SKIP;
                    end else begin
                        latch_idx  = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            SKIP: begin
                if (accept) state_next = HEADER;
            end
            DATA: begin
                if (accept) begin
                    load_data  = 1'b1;
                    state_next = STROBE;
                end
            end
            STROBE: begin
                state_next = HEADER;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            frame_idx    <= '0;
            FrameData    <= '0;
            FrameStrobe  <= '0;
            FrameError   <= 1'b0;
            ConfigActive <= 1'b0;
        end else begin
            state        <= state_next;
            ConfigActive <= (state_next != IDLE);
            // Strobe is only ever loaded for the single cycle after a data word.
            FrameStrobe  <= load_data ? dec_onehot : '0;
            if (latch_idx) frame_idx <= WriteData[HDR_FRAME_HI:HDR_FRAME_LO];
            if (load_data) FrameData <= FrameBitsPerRow'(WriteData);
            if (set_error) FrameError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_column_loader.sv
// tb/tb_frame_column_loader.sv - directed self-checking bench for frame_column_loader
module tb_frame_column_loader;

    logic        CLK;
    logic        resetn;
    logic [31:0] WriteData;
    logic        WriteValid;
    logic        WriteReady;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        ConfigActive;
    logic        FrameError;

    int n_checks = 0;
    int n_fail   = 0;

    frame_column_loader #(
        .MaxFramesPerCol(20),
        .FrameBitsPerRow(32),
        .ColumnIndex    (0)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .WriteData   (WriteData),
        .WriteValid  (WriteValid),
        .WriteReady  (WriteReady),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .ConfigActive(ConfigActive),
        .FrameError  (FrameError)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic xfer(input logic [31:0] w);
        int n;
        n = 0;
        while (WriteReady !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 10) chk("ready_timeout", {31'b0, WriteReady}, 32'h1);
        WriteData  = w;
        WriteValid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        WriteValid = 1'b0;
        WriteData  = 32'h0;
    endtask

    initial begin
        resetn     = 1'b1;
        WriteValid = 1'b0;
        WriteData  = 32'h0;
        #1 resetn  = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        chk("rst_strobe", {12'b0, FrameStrobe}, 32'h0);
        chk("rst_data",   FrameData,            32'h0);
        chk("rst_error",  {31'b0, FrameError},  32'h0);
        chk("rst_active", {31'b0, ConfigActive}, 32'h0);
        chk("rst_ready",  {31'b0, WriteReady},  32'h1);

        resetn = 1'b1;
        @(negedge CLK);

        // Words before sync are discarded.
        xfer(32'h0000_0001);
        chk("presync_strobe0", {12'b0, FrameStrobe}, 32'h0);
        xfer(32'hAAAA_AAAA);
        chk("presync_strobe1", {12'b0, FrameStrobe}, 32'h0);
        chk("presync_active",  {31'b0, ConfigActive}, 32'h0);
        chk("presync_data",    FrameData,            32'h0);

        // Basic write to frame 5.
        xfer(32'hFAB0_FAB1);
        chk("sync_active", {31'b0, ConfigActive}, 32'h1);
        xfer(32'h0000_0005);
        chk("hdr_nostrobe", {12'b0, FrameStrobe}, 32'h0);
        xfer(32'hDEAD_BEEF);
        chk("basic_data",   FrameData,            32'hDEAD_BEEF);
        chk("basic_strobe", {12'b0, FrameStrobe}, 32'h0000_0020);
        chk("basic_ready0", {31'b0, WriteReady},  32'h0);
        @(negedge CLK);
        chk("basic_strobe_drop", {12'b0, FrameStrobe}, 32'h0);
        chk("basic_ready1",      {31'b0, WriteReady},  32'h1);
        chk("basic_data_hold",   FrameData,            32'hDEAD_BEEF);

        // Foreign column header and its data are skipped.
        xfer(32'h0000_0305);
        xfer(32'h1234_5678);
        chk("foreign_strobe", {12'b0, FrameStrobe}, 32'h0);
        chk("foreign_data",   FrameData,            32'hDEAD_BEEF);
        xfer(32'h0000_0003);
        xfer(32'hCAFE_F00D);
        chk("after_foreign_data",   FrameData,            32'hCAFE_F00D);
        chk("after_foreign_strobe", {12'b0, FrameStrobe}, 32'h0000_0008);
        @(negedge CLK);

        // Highest legal index with bubbles between header and data.
        xfer(32'h0000_0013);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        chk("bubble_strobe", {12'b0, FrameStrobe}, 32'h0);
        chk("bubble_data",   FrameData,            32'hCAFE_F00D);
        xfer(32'h0BAD_CAFE);
        chk("idx19_data",   FrameData,            32'h0BAD_CAFE);
        chk("idx19_strobe", {12'b0, FrameStrobe}, 32'h0008_0000);
        @(negedge CLK);

        // Out-of-range frame index 20.
        xfer(32'h0000_0014);
        chk("oor_error", {31'b0, FrameError}, 32'h1);
        xfer(32'h5555_5555);
        chk("oor_strobe", {12'b0, FrameStrobe}, 32'h0);
        chk("oor_data",   FrameData,            32'h0BAD_CAFE);
        xfer(32'h0000_0000);
        xfer(32'h1111_1111);
        chk("post_oor_strobe", {12'b0, FrameStrobe}, 32'h0000_0001);
        chk("post_oor_data",   FrameData,            32'h1111_1111);
        chk("oor_sticky",      {31'b0, FrameError},  32'h1);
        @(negedge CLK);

        // Desync, then non-sync words are ignored.
        xfer(32'h8000_0000);
        chk("desync_active", {31'b0, ConfigActive}, 32'h0);
        xfer(32'h0000_0002);
        xfer(32'h9999_9999);
        chk("desync_strobe", {12'b0, FrameStrobe}, 32'h0);
        chk("desync_data",   FrameData,            32'h1111_1111);

        // Mid-frame asynchronous reset after header accepted.
        xfer(32'hFAB0_FAB1);
        xfer(32'h0000_0007);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_data",   FrameData,             32'h0);
        chk("mid_rst_error",  {31'b0, FrameError},   32'h0);
        chk("mid_rst_active", {31'b0, ConfigActive}, 32'h0);
        chk("mid_rst_strobe", {12'b0, FrameStrobe},  32'h0);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        xfer(32'h7777_7777);
        chk("post_rst_strobe", {12'b0, FrameStrobe},  32'h0);
        chk("post_rst_data",   FrameData,             32'h0);
        chk("post_rst_active", {31'b0, ConfigActive}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
